// File: rtl/axi_dmem_master_pkg.sv
`default_nettype none
// ============================================================================
// Module : axi_dmem_master_pkg
// Brief  : Shared AXI encodings, fixed routing IDs and the FSM state type
//          for the data-side AXI4 master.
// Rev    : 1.0  initial release
// ============================================================================
package axi_dmem_master_pkg;

  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam int         DMEM_AXI_ID = 1;
  localparam int         IMEM_AXI_ID = 0;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_WR_RESP = 3'd4,
    ST_RESP    = 3'd5
  } dmem_state_e;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != RESP_OKAY);
  endfunction

endpackage
`default_nettype wire

// File: rtl/axi_dmem_master.sv
`default_nettype none
// ============================================================================
// Module : axi_dmem_master
// Brief  : Converts the CPU load/store port into single-beat AXI4 read or
//          write transactions, one outstanding at a time. Completion is
//          returned to the LSU as a one-cycle rsp_valid pulse.
// Ports  : i_clk, i_rst            clock / async active-high reset
//          req_*                   LSU request (valid/ready handshake)
//          rsp_*                   LSU response pulse, load data, error flag
//          M_AXI_AR* / M_AXI_R*    read address / read data channels
//          M_AXI_AW* / M_AXI_W*    write address / write data channels
//          M_AXI_B*                write response channel
// Rev    : 1.0  initial release
// ============================================================================
module axi_dmem_master
  import axi_dmem_master_pkg::*;
#(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int STRB_WIDTH = DATA_WIDTH / 8,
  parameter int USER_WIDTH = 1,
  parameter int AXI_ID     = DMEM_AXI_ID
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  // LSU request
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [2:0]            req_size,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  input  logic [STRB_WIDTH-1:0] req_wstrb,
  // LSU response
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  rsp_err,
  // Read address channel
  output logic [ADDR_WIDTH-1:0] M_AXI_ARADDR,
  output logic                  M_AXI_ARVALID,
  input  logic                  M_AXI_ARREADY,
  output logic [7:0]            M_AXI_ARLEN,
  output logic [ID_WIDTH-1:0]   M_AXI_ARID,
  output logic [2:0]            M_AXI_ARSIZE,
  output logic [1:0]            M_AXI_ARBURST,
  output logic                  M_AXI_ARLOCK,
  output logic [3:0]            M_AXI_ARCACHE,
  output logic [2:0]            M_AXI_ARPROT,
  output logic [3:0]            M_AXI_ARQOS,
  output logic [3:0]            M_AXI_ARREGION,
  output logic [USER_WIDTH-1:0] M_AXI_ARUSER,
  // Read data channel
  input  logic [DATA_WIDTH-1:0] M_AXI_RDATA,
  input  logic                  M_AXI_RLAST,
  input  logic                  M_AXI_RVALID,
  input  logic [ID_WIDTH-1:0]   M_AXI_RID,
  input  logic [1:0]            M_AXI_RRESP,
  output logic                  M_AXI_RREADY,
  // Write address channel
  output logic [ADDR_WIDTH-1:0] M_AXI_AWADDR,
  output logic                  M_AXI_AWVALID,
  input  logic                  M_AXI_AWREADY,
  output logic [7:0]            M_AXI_AWLEN,
  output logic [ID_WIDTH-1:0]   M_AXI_AWID,
  output logic [2:0]            M_AXI_AWSIZE,
  output logic [1:0]            M_AXI_AWBURST,
  output logic                  M_AXI_AWLOCK,
  output logic [3:0]            M_AXI_AWCACHE,
  output logic [2:0]            M_AXI_AWPROT,
  output logic [3:0]            M_AXI_AWQOS,
  output logic [3:0]            M_AXI_AWREGION,
  output logic [USER_WIDTH-1:0] M_AXI_AWUSER,
  // Write data channel
  output logic [DATA_WIDTH-1:0] M_AXI_WDATA,
  output logic [STRB_WIDTH-1:0] M_AXI_WSTRB,
  output logic                  M_AXI_WLAST,
  output logic                  M_AXI_WVALID,
  input  logic                  M_AXI_WREADY,
  output logic [USER_WIDTH-1:0] M_AXI_WUSER,
  // Write response channel
  input  logic [ID_WIDTH-1:0]   M_AXI_BID,
  input  logic [1:0]            M_AXI_BRESP,
  input  logic                  M_AXI_BVALID,
  output logic                  M_AXI_BREADY
);

  localparam logic [ID_WIDTH-1:0] c_axi_id = ID_WIDTH'(AXI_ID);

  dmem_state_e           r_state;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [2:0]            r_size;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [STRB_WIDTH-1:0] r_wstrb;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic                  r_err;
  logic                  r_req_ready;
  logic                  r_rsp_valid;
  logic                  r_arvalid;
  logic                  r_rready;
  logic                  r_awvalid;
  logic                  r_wvalid;
  logic                  r_bready;
  logic                  r_aw_done;
  logic                  r_w_done;

  // AW and W complete independently; a channel counts as finished if it
  // completed earlier or is completing on this edge.
  logic w_aw_hs, w_w_hs, w_aw_fin, w_w_fin;
  assign w_aw_hs  = r_awvalid & M_AXI_AWREADY;
  assign w_w_hs   = r_wvalid  & M_AXI_WREADY;
  assign w_aw_fin = r_aw_done | w_aw_hs;
  assign w_w_fin  = r_w_done  | w_w_hs;

  // A beat that is not the last, or that carries a foreign ID, is still
  // consumed so the bus never hangs, but is reported as an error.
  logic w_rd_err;
  assign w_rd_err = resp_is_err(M_AXI_RRESP) | ~M_AXI_RLAST | (M_AXI_RID != c_axi_id);

  // BID carries no information for a single-outstanding master.
  logic w_unused_bid;
  assign w_unused_bid = ^M_AXI_BID;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_size      <= '0;
      r_wdata     <= '0;
      r_wstrb     <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_arvalid   <= 1'b0;
      r_rready    <= 1'b0;
      r_awvalid   <= 1'b0;
      r_wvalid    <= 1'b0;
      r_bready    <= 1'b0;
      r_aw_done   <= 1'b0;
      r_w_done    <= 1'b0;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          r_req_ready <= 1'b1;
          if (req_valid && r_req_ready) begin
            r_req_ready <= 1'b0;
            r_addr      <= req_addr;
            r_size      <= req_size;
            r_wdata     <= req_wdata;
            r_wstrb     <= req_wstrb;
            r_rdata     <= '0;
            r_err       <= 1'b0;
            if (req_we) begin
              r_awvalid <= 1'b1;
              r_wvalid  <= 1'b1;
              r_aw_done <= 1'b0;
              r_w_done  <= 1'b0;
              r_state   <= ST_WR_REQ;
            end else begin
              r_arvalid <= 1'b1;
              r_state   <= ST_RD_ADDR;
            end
          end
        end
        ST_RD_ADDR: begin
          // ARVALID is held regardless of how long the interconnect stalls.
          if (M_AXI_ARREADY) begin
            r_arvalid <= 1'b0;
            r_rready  <= 1'b1;
            r_state   <= ST_RD_DATA;
          end
        end
        ST_RD_DATA: begin
          if (M_AXI_RVALID) begin
            r_rready    <= 1'b0;
            r_rdata     <= M_AXI_RDATA;
            r_err       <= w_rd_err;
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_WR_REQ: begin
          if (w_aw_hs) begin
            r_awvalid <= 1'b0;
            r_aw_done <= 1'b1;
          end
          if (w_w_hs) begin
            r_wvalid <= 1'b0;
            r_w_done <= 1'b1;
          end
          if (w_aw_fin && w_w_fin) begin
            r_aw_done <= 1'b0;
            r_w_done  <= 1'b0;
            r_bready  <= 1'b1;
            r_state   <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (M_AXI_BVALID) begin
            r_bready    <= 1'b0;
            r_err       <= resp_is_err(M_AXI_BRESP);
            r_rsp_valid <= 1'b1;
            r_state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          // rsp_valid is high during this state; ready returns for IDLE.
          r_req_ready <= 1'b1;
          r_state     <= ST_IDLE;
        end
        default: begin
          r_req_ready <= 1'b0;
          r_arvalid   <= 1'b0;
          r_rready    <= 1'b0;
          r_awvalid   <= 1'b0;
          r_wvalid    <= 1'b0;
          r_bready    <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready      = r_req_ready;
  assign rsp_valid      = r_rsp_valid;
  assign rsp_rdata      = r_rdata;
  assign rsp_err        = r_err;

  assign M_AXI_ARADDR   = r_addr;
  assign M_AXI_ARVALID  = r_arvalid;
  assign M_AXI_ARLEN    = 8'd0;
  assign M_AXI_ARID     = c_axi_id;
  assign M_AXI_ARSIZE   = r_size;
  assign M_AXI_ARBURST  = BURST_INCR;
  assign M_AXI_ARLOCK   = 1'b0;
  assign M_AXI_ARCACHE  = 4'd0;
  assign M_AXI_ARPROT   = 3'd0;
  assign M_AXI_ARQOS    = 4'd0;
  assign M_AXI_ARREGION = 4'd0;
  assign M_AXI_ARUSER   = '0;
  assign M_AXI_RREADY   = r_rready;

  assign M_AXI_AWADDR   = r_addr;
  assign M_AXI_AWVALID  = r_awvalid;
  assign M_AXI_AWLEN    = 8'd0;
  assign M_AXI_AWID     = c_axi_id;
  assign M_AXI_AWSIZE   = r_size;
  assign M_AXI_AWBURST  = BURST_INCR;
  assign M_AXI_AWLOCK   = 1'b0;
  assign M_AXI_AWCACHE  = 4'd0;
  assign M_AXI_AWPROT   = 3'd0;
  assign M_AXI_AWQOS    = 4'd0;
  assign M_AXI_AWREGION = 4'd0;
  assign M_AXI_AWUSER   = '0;

  assign M_AXI_WDATA    = r_wdata;
  assign M_AXI_WSTRB    = r_wstrb;
  assign M_AXI_WLAST    = 1'b1;
  assign M_AXI_WVALID   = r_wvalid;
  assign M_AXI_WUSER    = '0;
  assign M_AXI_BREADY   = r_bready;

endmodule
`default_nettype wire

// File: tb/tb_axi_dmem_master.sv
`default_nettype none
// ============================================================================
// Module : tb_axi_dmem_master
// Brief  : Directed bench for axi_dmem_master with a configurable AXI slave,
//          a response scoreboard and a handshake-stability monitor.
// Rev    : 1.0  initial release
// ============================================================================
module tb_axi_dmem_master;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // LSU side
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic [2:0]  req_size;
  logic [7:0]  req_wstrb;
  logic        rsp_valid, rsp_err;
  logic [63:0] rsp_rdata;
  // AXI side
  logic [63:0] m_araddr, m_awaddr, m_rdata, m_wdata;
  logic        m_arvalid, m_arready, m_arlock, m_rlast, m_rvalid, m_rready;
  logic [7:0]  m_arlen, m_awlen, m_wstrb;
  logic [3:0]  m_arid, m_arcache, m_arqos, m_arregion, m_rid;
  logic [2:0]  m_arsize, m_arprot, m_awsize, m_awprot;
  logic [1:0]  m_arburst, m_rresp, m_awburst, m_bresp;
  logic [0:0]  m_aruser, m_awuser, m_wuser;
  logic        m_awvalid, m_awready, m_awlock, m_wlast, m_wvalid, m_wready;
  logic [3:0]  m_awid, m_awcache, m_awqos, m_awregion, m_bid;
  logic        m_bvalid, m_bready;

  axi_dmem_master dut (
    .i_clk(clk), .i_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_size(req_size), .req_wdata(req_wdata),
    .req_wstrb(req_wstrb),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .M_AXI_ARADDR(m_araddr), .M_AXI_ARVALID(m_arvalid), .M_AXI_ARREADY(m_arready),
    .M_AXI_ARLEN(m_arlen), .M_AXI_ARID(m_arid), .M_AXI_ARSIZE(m_arsize),
    .M_AXI_ARBURST(m_arburst), .M_AXI_ARLOCK(m_arlock), .M_AXI_ARCACHE(m_arcache),
    .M_AXI_ARPROT(m_arprot), .M_AXI_ARQOS(m_arqos), .M_AXI_ARREGION(m_arregion),
    .M_AXI_ARUSER(m_aruser),
    .M_AXI_RDATA(m_rdata), .M_AXI_RLAST(m_rlast), .M_AXI_RVALID(m_rvalid),
    .M_AXI_RID(m_rid), .M_AXI_RRESP(m_rresp), .M_AXI_RREADY(m_rready),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
    .M_AXI_AWLEN(m_awlen), .M_AXI_AWID(m_awid), .M_AXI_AWSIZE(m_awsize),
    .M_AXI_AWBURST(m_awburst), .M_AXI_AWLOCK(m_awlock), .M_AXI_AWCACHE(m_awcache),
    .M_AXI_AWPROT(m_awprot), .M_AXI_AWQOS(m_awqos), .M_AXI_AWREGION(m_awregion),
    .M_AXI_AWUSER(m_awuser),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WLAST(m_wlast),
    .M_AXI_WVALID(m_wvalid), .M_AXI_WREADY(m_wready), .M_AXI_WUSER(m_wuser),
    .M_AXI_BID(m_bid), .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid),
    .M_AXI_BREADY(m_bready)
  );

  // ---------------------------------------------------------------- checking
  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];
  int   rsp_log[$];

  // ---------------------------------------------------------- slave config
  int          ar_delay = 0, aw_delay = 0, w_delay = 0, r_delay = 0;
  logic [63:0] s_rdata = '0;
  logic [1:0]  s_rresp = 2'b00, s_bresp = 2'b00;
  logic        s_rlast = 1'b1;
  logic [3:0]  s_rid = 4'd1;
  int ar_hs_n = 0, aw_hs_n = 0, w_hs_n = 0;
  int arv_cycles = 0, awv_cycles = 0, wv_cycles = 0;
  int stab_viol = 0;
  int cyc = 0, acc_cyc = 0;

  // AXI slave: samples handshakes on the edge, drives 1 time unit later.
  initial begin
    int  ar_w, aw_w, w_w, r_w;
    bit  r_pend, aw_got, w_got, b_pend;
    ar_w = 0; aw_w = 0; w_w = 0; r_w = 0;
    r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
    m_arready = 0; m_rvalid = 0; m_rdata = '0; m_rresp = 0; m_rlast = 0; m_rid = 0;
    m_awready = 0; m_wready = 0; m_bvalid = 0; m_bresp = 0; m_bid = 0;
    forever begin
      @(posedge clk);
      if (!rst) begin
        if (m_arvalid && m_arready) begin ar_hs_n++; r_pend = 1; r_w = 0; end
        if (m_rvalid && m_rready) r_pend = 0;
        if (m_awvalid && m_awready) begin aw_hs_n++; aw_got = 1; end
        if (m_wvalid && m_wready) begin w_hs_n++; w_got = 1; end
        if (m_bvalid && m_bready) b_pend = 0;
        if (aw_got && w_got) begin b_pend = 1; aw_got = 0; w_got = 0; end
        if (m_arvalid) arv_cycles++;
        if (m_awvalid) awv_cycles++;
        if (m_wvalid) wv_cycles++;
      end
      #1;
      if (rst) begin
        ar_w = 0; aw_w = 0; w_w = 0; r_w = 0;
        r_pend = 0; aw_got = 0; w_got = 0; b_pend = 0;
        m_arready = 0; m_rvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 0;
      end else begin
        if (!m_arvalid) begin ar_w = 0; m_arready = 0; end
        else begin m_arready = (ar_w >= ar_delay); if (!m_arready) ar_w++; end
        if (!m_awvalid) begin aw_w = 0; m_awready = 0; end
        else begin m_awready = (aw_w >= aw_delay); if (!m_awready) aw_w++; end
        if (!m_wvalid) begin w_w = 0; m_wready = 0; end
        else begin m_wready = (w_w >= w_delay); if (!m_wready) w_w++; end
        m_rvalid = 0;
        if (r_pend) begin
          if (r_w >= r_delay) begin
            m_rvalid = 1; m_rdata = s_rdata; m_rresp = s_rresp;
            m_rlast = s_rlast; m_rid = s_rid;
          end else r_w++;
        end
        m_bvalid = b_pend; m_bresp = s_bresp; m_bid = 4'd1;
      end
    end
  end

  // Response scoreboard and valid-stability monitor.
  initial begin
    exp_t        e;
    bit          p_arv, p_arr, p_awv, p_awr, p_wv, p_wr;
    logic [63:0] p_araddr, p_awaddr, p_wdata;
    p_arv = 0; p_arr = 0; p_awv = 0; p_awr = 0; p_wv = 0; p_wr = 0;
    p_araddr = '0; p_awaddr = '0; p_wdata = '0;
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        p_arv = 0; p_awv = 0; p_wv = 0;
      end else begin
        if (req_valid && req_ready) acc_cyc = cyc;
        if (rsp_valid) begin
          rsp_log.push_back(cyc);
          if (sb.size() == 0) check("rsp_unexpected", {63'd0, rsp_valid}, 64'd0);
          else begin
            e = sb.pop_front();
            check("rsp_rdata", rsp_rdata, e.rdata);
            check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
            check("rsp_latency", 64'(cyc - acc_cyc), 64'(e.lat));
          end
        end
        if (p_arv && !p_arr && !(m_arvalid === 1'b1 && m_araddr === p_araddr)) stab_viol++;
        if (p_awv && !p_awr && !(m_awvalid === 1'b1 && m_awaddr === p_awaddr)) stab_viol++;
        if (p_wv && !p_wr && !(m_wvalid === 1'b1 && m_wdata === p_wdata)) stab_viol++;
        p_arv = m_arvalid; p_arr = m_arready; p_araddr = m_araddr;
        p_awv = m_awvalid; p_awr = m_awready; p_awaddr = m_awaddr;
        p_wv = m_wvalid; p_wr = m_wready; p_wdata = m_wdata;
      end
    end
  end

  // --------------------------------------------------------------- drivers
  task automatic issue(input logic we, input logic [63:0] addr, input logic [2:0] size,
                       input logic [63:0] wd, input logic [7:0] ws,
                       input logic [63:0] erd, input logic eerr, input int elat,
                       input bit push);
    int n;
    exp_t e;
    if (push) begin
      e.rdata = erd; e.err = eerr; e.lat = elat;
      sb.push_back(e);
    end
    req_valid = 1; req_we = we; req_addr = addr; req_size = size;
    req_wdata = wd; req_wstrb = ws;
    n = 0;
    do begin @(posedge clk); n++; end while (!req_ready && n < 50);
    check("req_accepted", {63'd0, req_ready}, 64'd1);
    #1;
    req_valid = 0;
  endtask

  task automatic wait_rsp();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin @(posedge clk); n++; end
    check("rsp_pending_timeout", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // --------------------------------------------------------------- sequence
  initial begin
    int b_ar, b_aw, b_w, b_arv, b_awv, b_wv, b_log, t0;
    rst = 1; req_valid = 0; req_we = 0; req_addr = '0; req_size = '0;
    req_wdata = '0; req_wstrb = '0;
    repeat (3) @(posedge clk);
    #1;
    // Reset state
    check("rst_req_ready", {63'd0, req_ready}, 64'd0);
    check("rst_valids", {59'd0, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready}, 64'd0);
    check("rst_rsp", {62'd0, rsp_valid, rsp_err}, 64'd0);
    check("rst_rdata", rsp_rdata, 64'd0);
    check("rst_araddr", m_araddr, 64'd0);
    rst = 0;
    @(posedge clk); #1;

    // 1: basic load
    s_rdata = 64'hDEAD_BEEF_0123_4567;
    issue(0, 64'h8000_0010, 3'd3, '0, '0, 64'hDEAD_BEEF_0123_4567, 0, 3, 1);
    check("ar_valid", {63'd0, m_arvalid}, 64'd1);
    check("ar_addr", m_araddr, 64'h8000_0010);
    check("ar_fields", {m_arlen, m_arid, 1'b0, m_arsize, m_arburst}, {8'd0, 4'd1, 1'b0, 3'd3, 2'b01});
    check("ax_tied0", {m_arlock, m_arcache, m_arprot, m_arqos, m_arregion, m_aruser,
                       m_awlock, m_awcache, m_awprot, m_awqos, m_awregion, m_awuser, m_wuser}, 64'd0);
    wait_rsp();

    // 2: store, AWREADY delayed 3 cycles, WREADY immediate
    b_awv = awv_cycles; b_wv = wv_cycles;
    aw_delay = 3;
    issue(1, 64'h8000_0020, 3'd3, 64'h5555_5555_5555_5555, 8'h0F, 64'd0, 0, 6, 1);
    check("aw_w_raise", {62'd0, m_awvalid, m_wvalid}, 64'd3);
    check("w_fields", {55'd0, m_wlast, m_wstrb}, {55'd0, 1'b1, 8'h0F});
    check("w_data", m_wdata, 64'h5555_5555_5555_5555);
    check("aw_addr", m_awaddr, 64'h8000_0020);
    check("aw_fields", {m_awlen, m_awid, 1'b0, m_awsize, m_awburst}, {8'd0, 4'd1, 1'b0, 3'd3, 2'b01});
    @(posedge clk); #1;
    check("w_dropped_aw_held", {62'd0, m_awvalid, m_wvalid}, 64'd2);
    wait_rsp();
    aw_delay = 0;
    check("aw_valid_cycles", 64'(awv_cycles - b_awv), 64'd4);
    check("w_valid_cycles", 64'(wv_cycles - b_wv), 64'd1);

    // 3: ARREADY low for 5 cycles; a new request while busy is ignored
    b_arv = arv_cycles; b_aw = aw_hs_n;
    ar_delay = 5; s_rdata = 64'h1122_3344_5566_7788;
    issue(0, 64'h8000_0100, 3'd2, '0, '0, 64'h1122_3344_5566_7788, 0, 8, 1);
    repeat (2) @(posedge clk);
    #1;
    req_valid = 1; req_we = 1; req_addr = 64'hBAD0_0000; req_wdata = 64'hFFFF;
    check("busy_req_ready", {63'd0, req_ready}, 64'd0);
    check("stall_ar_held", {63'd0, m_arvalid}, 64'd1);
    repeat (2) @(posedge clk);
    #1;
    check("stall_busy_ready", {63'd0, req_ready}, 64'd0);
    check("stall_araddr", m_araddr, 64'h8000_0100);
    req_valid = 0;
    wait_rsp();
    ar_delay = 0;
    check("ar_stall_cycles", 64'(arv_cycles - b_arv), 64'd6);
    check("busy_no_aw", 64'(aw_hs_n - b_aw), 64'd0);

    // 4: error responses
    s_rresp = 2'b10; s_rdata = 64'h0BAD;
    issue(0, 64'h8000_0200, 3'd3, '0, '0, 64'h0BAD, 1, 3, 1);
    wait_rsp();
    s_rresp = 2'b00; s_bresp = 2'b11;
    issue(1, 64'h8000_0208, 3'd3, 64'h77, 8'hFF, 64'd0, 1, 3, 1);
    wait_rsp();
    s_bresp = 2'b00; s_rlast = 0; s_rdata = 64'hCAFE;
    issue(0, 64'h8000_0210, 3'd3, '0, '0, 64'hCAFE, 1, 3, 1);
    wait_rsp();
    s_rlast = 1; s_rid = 4'd2; s_rdata = 64'hF00D;
    issue(0, 64'h8000_0218, 3'd3, '0, '0, 64'hF00D, 1, 3, 1);
    wait_rsp();
    s_rid = 4'd1;

    // 5: asynchronous reset in RD_DATA aborts without a response
    r_delay = 10; s_rdata = 64'h1234;
    issue(0, 64'h8000_0300, 3'd3, '0, '0, '0, 0, 0, 0);
    @(posedge clk); #1;
    check("in_rd_data", {63'd0, m_rready}, 64'd1);
    #2 rst = 1;
    #1;
    check("async_rst_valids", {58'd0, m_arvalid, m_rready, m_awvalid, m_wvalid, m_bready, rsp_valid}, 64'd0);
    check("async_rst_ready", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    rst = 0; r_delay = 0;
    repeat (15) @(posedge clk);
    #1;
    s_rdata = 64'h0A0B_0C0D;
    issue(0, 64'h8000_0308, 3'd3, '0, '0, 64'h0A0B_0C0D, 0, 3, 1);
    wait_rsp();

    // 6: back-to-back load, store, load with a zero-wait slave
    b_ar = ar_hs_n; b_aw = aw_hs_n; b_w = w_hs_n; b_log = rsp_log.size();
    s_rdata = 64'hAAAA_0001;
    issue(0, 64'h8000_0400, 3'd3, '0, '0, 64'hAAAA_0001, 0, 3, 1);
    t0 = acc_cyc;
    issue(1, 64'h8000_0408, 3'd3, 64'h99, 8'h01, 64'd0, 0, 3, 1);
    issue(0, 64'h8000_0410, 3'd3, '0, '0, 64'hAAAA_0001, 0, 3, 1);
    wait_rsp();
    check("b2b_rsp_count", 64'(rsp_log.size() - b_log), 64'd3);
    if (rsp_log.size() >= b_log + 3) begin
      check("b2b_rsp0_cycle", 64'(rsp_log[b_log] - t0), 64'd3);
      check("b2b_rsp1_cycle", 64'(rsp_log[b_log+1] - t0), 64'd7);
      check("b2b_rsp2_cycle", 64'(rsp_log[b_log+2] - t0), 64'd11);
    end
    check("b2b_ar_count", 64'(ar_hs_n - b_ar), 64'd2);
    check("b2b_aw_count", 64'(aw_hs_n - b_aw), 64'd1);
    check("b2b_w_count", 64'(w_hs_n - b_w), 64'd1);
    check("valid_stability", 64'(stab_viol), 64'd0);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
